// File: rtl/ibex_rf_pkg.sv
// ibex_rf_pkg: types and constants shared across the Ibex register-file hierarchy.
//    rf_l2_state_e : L2 responder FSM states
//    RfAddrW       : register index width
//    rf_l2_req_t   : L1 -> L2 request bundle, shared with the L1 cache controller
//    rf_addr_err   : true when an index names a register absent in RV32E mode
package ibex_rf_pkg;

   localparam int unsigned RfAddrW = 5;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } rf_l2_state_e;

   typedef struct packed {
      logic               we;
      logic [RfAddrW-1:0] addr;
      logic [31:0]        wdata;
   } rf_l2_req_t;

   function automatic logic rf_addr_err(input logic [RfAddrW-1:0] addr, input bit rv32e);
      return rv32e && addr[RfAddrW-1];
   endfunction

endpackage

// File: rtl/ibex_rf_l2_array.sv
// ibex_rf_l2_array: flop storage for the L2 register file, one write and one read port.
//    clk_i, rst_ni : clock, async active-low reset (clears every entry)
//    we_i, waddr_i, wdata_i : write port, x0 and non-existent registers are dropped
//    raddr_i       : read index
//    rdata_o       : read data, 0 for x0 and non-existent registers
//    rerr_o        : read index names a register absent in RV32E mode
module ibex_rf_l2_array
   import ibex_rf_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter bit          RV32E     = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 we_i,
   input  logic [RfAddrW-1:0]   waddr_i,
   input  logic [DataWidth-1:0] wdata_i,
   input  logic [RfAddrW-1:0]   raddr_i,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 rerr_o
);

   localparam int unsigned AW      = RV32E ? 4 : 5;
   localparam int unsigned NumRegs = 1 << AW;

   logic [DataWidth-1:0] mem_q [NumRegs];
   logic                 wr_ok;

   assign wr_ok   = we_i && !rf_addr_err(waddr_i, RV32E) && waddr_i != '0;
   assign rerr_o  = rf_addr_err(raddr_i, RV32E);
   assign rdata_o = (rerr_o || raddr_i == '0) ? '0 : mem_q[raddr_i[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= '{default: '0};
      end else if (wr_ok) begin
         mem_q[waddr_i[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/ibex_rf_l2_responder.sv
// ibex_rf_l2_responder: L2 register-storage responder serving one L1 request at a time.
//    clk_i, rst_ni        : clock, async active-low reset
//    req_i, we_i, addr_i, wdata_i : request from the L1 side, held until gnt_o
//    gnt_o                : request accepted this cycle (combinational)
//    rvalid_o, rdata_o, err_o : registered one-cycle response
//    busy_o               : read in flight
//    rd_cnt_o, wr_cnt_o   : saturating counts of granted reads / writes
module ibex_rf_l2_responder
   import ibex_rf_pkg::*;
#(
   parameter int unsigned DataWidth   = 32,
   parameter bit          RV32E       = 1'b0,
   parameter int unsigned ReadLatency = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [RfAddrW-1:0]   addr_i,
   input  logic [DataWidth-1:0] wdata_i,
   output logic                 gnt_o,
   output logic                 rvalid_o,
   output logic [DataWidth-1:0] rdata_o,
   output logic                 err_o,
   output logic                 busy_o,
   output logic [15:0]          rd_cnt_o,
   output logic [15:0]          wr_cnt_o
);

   if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_latency
      $fatal(1, "ReadLatency must be in 1..4");
   end

   // BUSY covers grant+1 .. grant+ReadLatency-1, so the counter starts at ReadLatency-2
   localparam logic [1:0] LatInit = (ReadLatency > 1) ? 2'(ReadLatency - 2) : 2'd0;

   rf_l2_state_e         state_q, state_d;
   logic [1:0]           lat_q, lat_d;
   logic [RfAddrW-1:0]   addr_q, addr_d;
   logic                 rvalid_q, rvalid_d, err_q, err_d;
   logic [DataWidth-1:0] rdata_q, rdata_d;
   logic [15:0]          rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [RfAddrW-1:0]   arr_raddr;
   logic [DataWidth-1:0] arr_rdata;
   logic                 arr_err;

   assign gnt_o     = req_i && state_q != BUSY;
   // Outside BUSY the read port looks at the incoming index so a latency-1 read
   // and the write error check resolve at the grant edge.
   assign arr_raddr = (state_q == BUSY) ? addr_q : addr_i;

   ibex_rf_l2_array #(
      .DataWidth(DataWidth),
      .RV32E    (RV32E)
   ) u_array (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .we_i   (gnt_o && we_i),
      .waddr_i(addr_i),
      .wdata_i(wdata_i),
      .raddr_i(arr_raddr),
      .rdata_o(arr_rdata),
      .rerr_o (arr_err)
   );

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      addr_d   = addr_q;
      rvalid_d = 1'b0;
      rdata_d  = '0;
      err_d    = 1'b0;
      rd_cnt_d = (gnt_o && !we_i && rd_cnt_q != 16'hFFFF) ? rd_cnt_q + 16'd1 : rd_cnt_q;
      wr_cnt_d = (gnt_o && we_i && wr_cnt_q != 16'hFFFF) ? wr_cnt_q + 16'd1 : wr_cnt_q;
      if (state_q == BUSY) begin
         if (lat_q == 2'd0) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rdata_d  = arr_rdata;
            err_d    = arr_err;
         end else begin
            lat_d = lat_q - 2'd1;
         end
      end else if (gnt_o) begin
         if (we_i) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            err_d    = arr_err;
         end else begin
            addr_d = addr_i;
            if (ReadLatency == 1) begin
               state_d  = RESP;
               rvalid_d = 1'b1;
               rdata_d  = arr_rdata;
               err_d    = arr_err;
            end else begin
               state_d = BUSY;
               lat_d   = LatInit;
            end
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         lat_q    <= '0;
         addr_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         lat_q    <= lat_d;
         addr_q   <= addr_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;
   assign busy_o   = state_q == BUSY;
   assign rd_cnt_o = rd_cnt_q;
   assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_ibex_rf_l2_responder.sv
// tb_ibex_rf_l2_responder: three responders (lat 1, lat 3 RV32E, lat 4) against a transaction-level model.
module tb_ibex_rf_l2_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req [3];
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        gnt [3], rvalid [3], err [3], busy [3];
   logic [31:0] rdata [3];
   logic [15:0] rdc [3], wrc [3];

   int unsigned lat_m [3] = '{1, 3, 4};
   bit          e_m   [3] = '{1'b0, 1'b1, 1'b0};
   logic [31:0] mem_m [3][32];
   int unsigned rd_m  [3], wr_m [3];
   int          n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 3; i++) begin : g_dut
      ibex_rf_l2_responder #(
         .DataWidth  (32),
         .RV32E      (i == 1),
         .ReadLatency(i == 0 ? 1 : (i == 1 ? 3 : 4))
      ) u_dut (
         .clk_i   (clk),
         .rst_ni  (rst_n),
         .req_i   (req[i]),
         .we_i    (we),
         .addr_i  (addr),
         .wdata_i (wdata),
         .gnt_o   (gnt[i]),
         .rvalid_o(rvalid[i]),
         .rdata_o (rdata[i]),
         .err_o   (err[i]),
         .busy_o  (busy[i]),
         .rd_cnt_o(rdc[i]),
         .wr_cnt_o(wrc[i])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned sat(input int unsigned v);
      return (v < 32'hFFFF) ? v + 1 : v;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 3; d++) begin
         rd_m[d] = 0;
         wr_m[d] = 0;
         for (int r = 0; r < 32; r++) mem_m[d][r] = '0;
      end
   endtask

   // One complete request on DUT d, starting and ending just after a falling edge in IDLE.
   task automatic xact(input int d, input bit w, input logic [4:0] a, input logic [31:0] wd);
      int          n;
      bit          exists;
      logic [31:0] exp_d;
      exists = !(e_m[d] && a[4]);
      exp_d  = (!w && exists && a != 0) ? mem_m[d][a] : 32'h0;
      req[d] = 1'b1; we = w; addr = a; wdata = wd;
      #1;
      n = 0;
      while (!gnt[d] && n < 8) begin @(negedge clk); #1; n++; end
      chk("gnt_wait", 32'(n < 8), 32'd1);
      if (w && exists && a != 0) mem_m[d][a] = wd;
      if (w) wr_m[d] = sat(wr_m[d]); else rd_m[d] = sat(rd_m[d]);
      @(negedge clk); req[d] = 1'b0; #1;
      n = 1;
      while (!rvalid[d] && n < 8) begin @(negedge clk); #1; n++; end
      chk("resp_latency", 32'(n), w ? 32'd1 : 32'(lat_m[d]));
      chk("resp_rdata", rdata[d], exp_d);
      chk("resp_err", 32'(err[d]), 32'(!exists));
      chk("rd_cnt", 32'(rdc[d]), rd_m[d]);
      chk("wr_cnt", 32'(wrc[d]), wr_m[d]);
      @(negedge clk); #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk({tag, "_rvalid"}, 32'(rvalid[d]), 32'd0);
         chk({tag, "_rdata"}, rdata[d], 32'd0);
         chk({tag, "_err"}, 32'(err[d]), 32'd0);
         chk({tag, "_busy"}, 32'(busy[d]), 32'd0);
         chk({tag, "_rdcnt"}, 32'(rdc[d]), 32'd0);
         chk({tag, "_wrcnt"}, 32'(wrc[d]), 32'd0);
      end
   endtask

   initial begin
      logic [31:0] v;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) req[d] = 1'b0;
      we = 1'b0; addr = '0; wdata = '0;
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1; #1;

      // x0: write acknowledged, read returns 0, one access each (lat 4, fresh counters)
      xact(2, 1'b1, 5'd0, 32'h1234);
      xact(2, 1'b0, 5'd0, 32'h0);
      chk("x0_wrcnt", 32'(wrc[2]), 32'd1);
      chk("x0_rdcnt", 32'(rdc[2]), 32'd1);

      // latency 1: write x5 then read x5 back-to-back
      req[0] = 1'b1; we = 1'b1; addr = 5'd5; wdata = 32'hDEADBEEF; #1;
      chk("b2b_wr_gnt", 32'(gnt[0]), 32'd1);
      @(negedge clk); #1;
      chk("b2b_wr_rvalid", 32'(rvalid[0]), 32'd1);
      chk("b2b_wr_err", 32'(err[0]), 32'd0);
      chk("b2b_wr_rdata", rdata[0], 32'd0);
      we = 1'b0; wdata = $urandom; #1;
      chk("b2b_rd_gnt", 32'(gnt[0]), 32'd1);
      @(negedge clk); req[0] = 1'b0; #1;
      chk("b2b_rd_rvalid", 32'(rvalid[0]), 32'd1);
      chk("b2b_rd_rdata", rdata[0], 32'hDEADBEEF);
      chk("b2b_rd_err", 32'(err[0]), 32'd0);
      mem_m[0][5] = 32'hDEADBEEF; wr_m[0] = 1; rd_m[0] = 1;
      @(negedge clk); #1;
      chk("b2b_idle_rvalid", 32'(rvalid[0]), 32'd0);

      // latency 3: read x7 with req held, second read granted in the RESP cycle
      v = $urandom;
      xact(1, 1'b1, 5'd7, v);
      req[1] = 1'b1; we = 1'b0; addr = 5'd7; #1;
      chk("l3_gnt_g", 32'(gnt[1]), 32'd1);
      @(negedge clk); #1;
      chk("l3_gnt_g1", 32'(gnt[1]), 32'd0);
      chk("l3_busy_g1", 32'(busy[1]), 32'd1);
      chk("l3_rvalid_g1", 32'(rvalid[1]), 32'd0);
      @(negedge clk); #1;
      chk("l3_gnt_g2", 32'(gnt[1]), 32'd0);
      chk("l3_busy_g2", 32'(busy[1]), 32'd1);
      chk("l3_rvalid_g2", 32'(rvalid[1]), 32'd0);
      @(negedge clk); #1;
      chk("l3_rvalid_g3", 32'(rvalid[1]), 32'd1);
      chk("l3_rdata_g3", rdata[1], v);
      chk("l3_busy_g3", 32'(busy[1]), 32'd0);
      chk("l3_gnt_resp", 32'(gnt[1]), 32'd1);
      @(negedge clk); req[1] = 1'b0; #1;
      chk("l3_busy_2nd", 32'(busy[1]), 32'd1);
      @(negedge clk); #1;
      chk("l3_rvalid_2nd_early", 32'(rvalid[1]), 32'd0);
      @(negedge clk); #1;
      chk("l3_rvalid_2nd", 32'(rvalid[1]), 32'd1);
      chk("l3_rdata_2nd", rdata[1], v);
      rd_m[1] += 2;
      chk("l3_rdcnt", 32'(rdc[1]), rd_m[1]);
      @(negedge clk); #1;

      // RV32E: x20 does not exist and must not alias x4
      xact(1, 1'b1, 5'd4, 32'hA5A5_0004);
      xact(1, 1'b1, 5'd20, 32'h0000_00FF);
      xact(1, 1'b0, 5'd20, 32'h0);
      xact(1, 1'b0, 5'd4, 32'h0);

      // random traffic across all three configurations
      for (int k = 0; k < 60; k++)
         xact(int'($urandom_range(0, 2)), 1'($urandom), 5'($urandom), $urandom);

      // reset in the middle of a 4-cycle read
      xact(2, 1'b1, 5'd9, 32'h0BAD_F00D | 32'h1);
      req[2] = 1'b1; we = 1'b0; addr = 5'd9; #1;
      @(negedge clk); #1;
      @(negedge clk);
      rst_n = 1'b0; #1;
      req[2] = 1'b0;
      #1;
      chk_reset_outputs("midreset");
      model_clear();
      @(negedge clk); #1;
      chk("midreset_hold_rvalid", 32'(rvalid[2]), 32'd0);
      @(negedge clk); rst_n = 1'b1; #1;
      for (int k = 0; k < 4; k++) begin
         chk("post_reset_no_rvalid", 32'(rvalid[2]), 32'd0);
         @(negedge clk); #1;
      end
      xact(2, 1'b0, 5'd9, 32'h0);

      // read counter saturation on the latency-1 instance
      req[0] = 1'b1; we = 1'b0; addr = 5'($urandom); #1;
      repeat (65534) @(negedge clk);
      req[0] = 1'b0; #1;
      chk("sat_preload", 32'(rdc[0]), 32'h0000_FFFE);
      rd_m[0] = 32'hFFFE;
      @(negedge clk); #1;
      for (int k = 0; k < 3; k++) xact(0, 1'b0, 5'($urandom), 32'h0);
      chk("sat_final", 32'(rdc[0]), 32'h0000_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
